// File: rtl/sd_cdc_pkg.sv
// Shared types and constants for the CDC source-side arbiter.
package sd_cdc_pkg;

  // Default payload width in bits.
  localparam int DEFAULT_WIDTH = 8;

  // Transfer sequencer states (binary encoded).
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester with req set,
// searching upward from (last_gnt + 1) and wrapping at NREQ.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req_i,
  input  logic [$clog2(NREQ)-1:0] last_gnt_i,
  output logic [$clog2(NREQ)-1:0] winner_o,
  output logic                    valid_o
);

  localparam int            IW       = $clog2(NREQ);
  localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

  logic [IW-1:0] cand;

  // Walk the candidates in rotation order and keep the first one requesting.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // one unassigned and no latch is inferred.
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = last_gnt_i;
    for (int off = 0; off < NREQ; off++) begin
      cand = (cand == LAST_IDX) ? '0 : cand + IW'(1);
      if (!valid_o && req_i[cand]) begin
        valid_o  = 1'b1;
        winner_o = cand;
      end
    end
  end

endmodule

// File: rtl/cdc_src_arbiter.sv
// Round-robin arbiter feeding a single CDC handshake source port. One
// transfer at a time: IDLE picks a winner and latches its payload, LAUNCH
// strobes src_val, WAIT holds until src_ack, DONE acks the requester.
// A sticky watchdog flags a WAIT lasting TIMEOUT cycles without abandoning it.
module cdc_src_arbiter
  import sd_cdc_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ack,
  output logic [WIDTH-1:0]        src,
  output logic                    src_val,
  input  logic                    src_ack,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] gnt_id,
  output logic                    timeout_err,
  input  logic                    timeout_clr
);

  localparam int            IW       = $clog2(NREQ);
  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
  localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

  state_e        state_q, state_d;
  logic [WIDTH-1:0] src_q, src_d;
  logic [IW-1:0] gnt_q, gnt_d;
  logic [IW-1:0] last_q, last_d;
  logic [CW-1:0] wd_q, wd_d;
  logic          err_q, err_d;

  logic [IW-1:0]    win_idx;
  logic             win_val;
  logic [WIDTH-1:0] data_arr [NREQ];

  // Split the flat payload bus into one word per requester.
  for (genvar g = 0; g < NREQ; g++) begin : g_split
    assign data_arr[g] = req_data[g*WIDTH +: WIDTH];
  end

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req_i      (req),
    .last_gnt_i (last_q),
    .winner_o   (win_idx),
    .valid_o    (win_val)
  );

  // Next-state, datapath updates and Moore outputs of the transfer sequencer.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wd_d    = wd_q;
    err_d   = timeout_clr ? 1'b0 : err_q;
    src_val = 1'b0;
    req_ack = '0;
    busy    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (win_val) begin
          state_d = ST_LAUNCH;
          src_d   = data_arr[win_idx];
          gnt_d   = win_idx;
        end
      end
      ST_LAUNCH: begin
        src_val = 1'b1;
        if (src_ack) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WAIT;
          wd_d    = '0;
        end
      end
      ST_WAIT: begin
        // Saturating watchdog; the set is applied after the clear so it wins.
        if (wd_q != TMO) begin
          wd_d = wd_q + CW'(1);
          if (wd_d == TMO) err_d = 1'b1;
        end
        if (src_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        req_ack[gnt_q] = 1'b1;
        last_d         = gnt_q;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      wd_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      src_q   <= src_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  assign src         = src_q;
  assign gnt_id      = gnt_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_cdc_src_arbiter.sv
// Scoreboard bench for cdc_src_arbiter: rounds of requests are issued, a
// round-robin model predicts the grant sequence into a queue, and a monitor
// compares each launch and completion against it.
module tb_cdc_src_arbiter;

  localparam int WIDTH   = 8;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req;
  logic [NREQ*WIDTH-1:0]   req_data;
  logic [NREQ-1:0]         req_ack;
  logic [WIDTH-1:0]        src;
  logic                    src_val;
  logic                    src_ack;
  logic                    busy;
  logic [$clog2(NREQ)-1:0] gnt_id;
  logic                    timeout_err;
  logic                    timeout_clr;

  cdc_src_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .src         (src),
    .src_val     (src_val),
    .src_ack     (src_ack),
    .busy        (busy),
    .gnt_id      (gnt_id),
    .timeout_err (timeout_err),
    .timeout_clr (timeout_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } xfer_t;

  xfer_t            exp_q[$];
  int               checks   = 0;
  int               failures = 0;
  int               model_last;
  int               load_cnt  [NREQ];
  logic [WIDTH-1:0] load_data [NREQ];
  int               load_seq = 0;
  int               man_seq  = 0;
  bit               auto_ack = 1'b1;
  int               ack_delay = -1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every requester in the round keeps its request up until
  // it has been served load_cnt times; grants rotate from the last winner.
  task automatic issue_round();
    int left [NREQ];
    int total = 0;
    int pos   = model_last;
    for (int i = 0; i < NREQ; i++) begin
      left[i] = load_cnt[i];
      total  += load_cnt[i];
    end
    while (total > 0) begin
      for (int off = 1; off <= NREQ; off++) begin
        int k = (pos + off) % NREQ;
        if (left[k] > 0) begin
          exp_q.push_back('{k, load_data[k]});
          left[k]--;
          total--;
          pos = k;
          break;
        end
      end
    end
    model_last = pos;
    load_seq++;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(exp_q.size() == 0 && busy == 1'b0 && req == '0) && n < 2000);
    check({"drain_", tag}, (n < 2000), 1);
  endtask

  task automatic wait_src_val(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!src_val && n < 50);
    check({"launch_", tag}, src_val, 1);
  endtask

  // Requesters: hold req while transfers remain, drop on the acked cycle.
  initial begin
    int left [NREQ];
    int seen = 0;
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    req      = '0;
    req_data = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (req_ack[i] && left[i] > 0) left[i]--;
      if (load_seq != seen) begin
        seen = load_seq;
        for (int i = 0; i < NREQ; i++) begin
          left[i] = load_cnt[i];
          req_data[i*WIDTH +: WIDTH] = load_data[i];
        end
      end
      for (int i = 0; i < NREQ; i++) req[i] = (left[i] > 0);
    end
  end

  // CDC port responder: acks each launch after a delay, or on manual request.
  initial begin
    int cd        = 0;
    int man_seen  = 0;
    bit armed     = 1'b0;
    bit chk       = 1'b0;
    logic a;
    src_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (chk) check("req_ack_one_cycle_after_src_ack", |req_ack, 1);
      chk = 1'b0;
      a   = 1'b0;
      if (man_seq != man_seen) begin
        man_seen = man_seq;
        a        = 1'b1;
      end
      if (rst) begin
        armed = 1'b0;
      end else if (auto_ack && src_val) begin
        cd    = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 4));
        armed = 1'b1;
      end
      if (armed) begin
        if (cd == 0) begin
          a     = 1'b1;
          armed = 1'b0;
          chk   = 1'b1;
        end else begin
          cd--;
        end
      end
      src_ack = a;
    end
  end

  // Monitor: pops the expected grant on each launch, checks its completion.
  initial begin
    xfer_t cur;
    bit    have    = 1'b0;
    bit    after   = 1'b0;
    bit    sv_prev = 1'b0;
    int    vals    = 0;
    cur = '{0, '0};
    forever begin
      @(negedge clk);
      if (rst) begin
        have    = 1'b0;
        after   = 1'b0;
        sv_prev = 1'b0;
        vals    = 0;
      end else begin
        if (after) begin
          check("idle_between_grants", busy, 0);
          check("req_ack_pulse_width", req_ack, 0);
          after = 1'b0;
        end
        if (sv_prev) check("src_val_pulse_width", src_val, 0);
        sv_prev = src_val;
        if (src_val) begin
          vals++;
          check("src_val_expected", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) cur = exp_q.pop_front();
          check("gnt_id", gnt_id, cur.id);
          check("src_payload", src, cur.data);
          have = 1'b1;
        end
        if (req_ack != '0) begin
          check("req_ack_expected", have, 1);
          check("req_ack_onehot", req_ack, 32'd1 << cur.id);
          check("src_stable", src, cur.data);
          check("src_val_per_grant", vals, 1);
          vals  = 0;
          have  = 1'b0;
          after = 1'b1;
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    int wd_id;
    rst         = 1'b0;
    timeout_clr = 1'b0;
    model_last  = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      load_cnt[i]  = 0;
      load_data[i] = '0;
    end
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_src", src, 0);
    check("rst_src_val", src_val, 0);
    check("rst_req_ack", req_ack, 0);
    check("rst_busy", busy, 0);
    check("rst_gnt_id", gnt_id, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Fairness: all four held, requester 0 twice -> 0,1,2,3,0.
    ack_delay = 2;
    load_cnt  = '{2, 1, 1, 1};
    load_data = '{8'h4f, 8'h46, 8'h6e, 8'h2c};
    issue_round();
    wait_idle("fair");

    // Single request, ack three cycles after the launch.
    ack_delay = 3;
    load_cnt  = '{1, 0, 0, 0};
    load_data = '{8'h4f, 8'h00, 8'h00, 8'h00};
    issue_round();
    wait_idle("single");

    // Rotation: after a grant to 2, requesters 0 and 3 -> 3 then 0.
    load_cnt = '{0, 0, 1, 0};
    load_data[2] = 8'ha5;
    issue_round();
    wait_idle("rot_a");
    load_cnt  = '{1, 0, 0, 1};
    load_data = '{8'h11, 8'h00, 8'ha5, 8'h33};
    issue_round();
    wait_idle("rot_b");

    // Spurious ack in IDLE changes nothing.
    repeat (2) @(negedge clk);
    #1 man_seq++;
    repeat (3) begin
      @(negedge clk);
      check("spurious_busy", busy, 0);
      check("spurious_req_ack", req_ack, 0);
    end

    // Randomised rounds, including acks arriving during LAUNCH.
    ack_delay = -1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        load_cnt[i]  = int'($urandom_range(0, 2));
        load_data[i] = WIDTH'($urandom);
      end
      issue_round();
      wait_idle("rand");
    end

    // Watchdog: ack withheld past TIMEOUT cycles of WAIT.
    auto_ack = 1'b0;
    wd_id    = 2;
    load_cnt = '{0, 0, 1, 0};
    load_data[wd_id] = 8'h5a;
    issue_round();
    wait_src_val("wd");
    for (int n = 1; n <= 21; n++) begin
      @(negedge clk);
      case (n)
        15: begin
          check("wd_err_early", timeout_err, 0);
          check("wd_src_held", src, 8'h5a);
        end
        16: timeout_clr = 1'b1;
        17: begin
          timeout_clr = 1'b0;
          check("wd_set_beats_clr", timeout_err, 1);
          check("wd_busy", busy, 1);
        end
        18: timeout_clr = 1'b1;
        19: begin
          timeout_clr = 1'b0;
          check("wd_clr", timeout_err, 0);
          check("wd_still_waiting", busy, 1);
          #1 man_seq++;
        end
        21: check("wd_late_ack_completes", req_ack, 32'd1 << wd_id);
        default: ;
      endcase
    end
    wait_idle("wd");

    // Reset in the middle of WAIT while requester 1 holds the grant.
    load_cnt = '{0, 1, 0, 0};
    load_data[1] = 8'hc3;
    issue_round();
    wait_src_val("rst");
    repeat (2) @(negedge clk);
    check("mid_gnt_id", gnt_id, 1);
    check("mid_busy", busy, 1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_src", src, 0);
    check("mid_rst_src_val", src_val, 0);
    check("mid_rst_req_ack", req_ack, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_gnt_id", gnt_id, 0);
    check("mid_rst_timeout_err", timeout_err, 0);
    load_cnt = '{0, 0, 0, 0};
    exp_q.delete();
    issue_round();
    model_last = NREQ - 1;
    repeat (2) begin
      @(negedge clk);
      check("in_rst_req_ack", req_ack, 0);
    end
    rst      = 1'b0;
    auto_ack = 1'b1;
    load_cnt  = '{1, 0, 1, 0};
    load_data = '{8'h77, 8'h00, 8'h88, 8'h00};
    issue_round();
    wait_idle("post_rst");

    repeat (5) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "bench time limit");
  end

endmodule
